// File: rtl/bcd_to_decimal_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_decimal_stream_decoder
// Description : Accepts a packed multi-digit BCD word and emits one one-hot
//               10-bit decimal code per digit, LSD first, over valid/ready.
//               Codes 4'hA-4'hF (or unknown bits) are flagged with out_err.
// Options     : define ERR_CNT_EN to add the saturating 8-bit err_cnt output.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_decimal_stream_decoder #(
  parameter int DIGITS = 4,
  parameter int IDX_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   in_bcd,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [9:0]            out_dec,
  output logic                  out_err,
  output logic [IDX_W-1:0]      out_idx,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef ERR_CNT_EN
  ,
  output logic [7:0]            err_cnt
`endif
);

  localparam int              W        = 4 * DIGITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     sr_q, sr_d;       // digits still waiting to be emitted, next one in [3:0]
  logic [9:0]       dec_q, dec_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             last_q, last_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] w_idx_inc;
  logic             w_xfer;

  // {err, one-hot}; an unknown or >9 code fails the compare and lands in the error branch
  function automatic logic [10:0] decode_digit(input logic [3:0] v);
    logic [10:0] r;
    r = {1'b1, 10'b0};
    if (v < 4'd10) begin
      r = {1'b0, 10'd1 << v};
    end
    return r;
  endfunction

  assign w_xfer    = valid_q && out_ready;
  assign w_idx_inc = idx_q + IDX_W'(1);

  // Next-state and next-output logic for the accept/emit sequencer
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    dec_d   = dec_q;
    err_d   = err_q;
    idx_d   = idx_q;
    last_d  = last_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d        = ST_EMIT;
          {err_d, dec_d} = decode_digit(in_bcd[3:0]);
          sr_d           = in_bcd >> 4;
          idx_d          = '0;
          last_d         = (LAST_IDX == '0);
          valid_d        = 1'b1;
        end
      end
      ST_EMIT: begin
        if (w_xfer) begin
          if (last_q) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
          end else begin
            {err_d, dec_d} = decode_digit(sr_q[3:0]);
            sr_d           = sr_q >> 4;
            idx_d          = w_idx_inc;
            last_d         = (w_idx_inc == LAST_IDX);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any word in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      dec_q   <= '0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      dec_q   <= dec_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_dec   = dec_q;
  assign out_err   = err_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;
  assign out_valid = valid_q;

`ifdef ERR_CNT_EN
  logic [7:0] err_cnt_q;

  // Count transferred error digits, sticking at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= 8'd0;
    end else if (w_xfer && err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
`default_nettype wire
